shared_multiplier_scheduler: RTL
================================

// Module: shared_multiplier_scheduler
// PURPOSE
//  Shares one combinational long_multiplier among N_REQ requesters. A round-robin arbiter grants one
//  request at a time, latches its operands and waits MULT_CYCLES cycles for the multiplier
//  (a multicycle path). It registers the product and tags it with the requester id.
//  Sits between the integer-unit issue ports and the single array multiplier instance.
// PARAMETERS
//  DATA_WIDTH   8  operand width; must be a power of 2; product is 2*DATA_WIDTH bits
//  N_REQ        4  number of requesters; must be >= 2; ID_W = $clog2(N_REQ)
//  MULT_CYCLES  2  cycles allowed for the combinational multiplier to settle; must be >= 1
// PORTS
//  clk_i            in   1                 clock, all logic on rising edge
//  rst_n_i          in   1                 synchronous active-low reset
//  req_valid_i      in   N_REQ             per-requester request valid
//  req_ready_o      out  N_REQ             per-requester accept, one-hot or zero
//  req_operand_A_i  in   N_REQ*DATA_WIDTH  multiplicand, per requester
//  req_operand_B_i  in   N_REQ*DATA_WIDTH  multiplier, per requester
//  req_signed_i     in   N_REQ             two's-complement flag; port exists only with MUL_SCHED_SIGNED_EN
//  result_valid_o   out  1                 result_o/result_id_o valid
//  result_ready_i   in   1                 consumer accepts result
//  result_o         out  2*DATA_WIDTH      registered product
//  result_id_o      out  ID_W              index of requester that owns result_o
//  busy_o           out  1                 high in COMPUTE or DONE
// BEHAVIOUR
//  Reset (rst_n_i=0 at a clock edge): state=IDLE, rr pointer=N_REQ-1 (req 0 has top priority),
//   result_o=0, result_id_o=0, result_valid_o=0, busy_o=0, operand regs=0. Reset mid-operation
//   discards the in-flight request; no result is produced; the requester must re-issue.
//  FSM: IDLE -> COMPUTE -> DONE -> IDLE.
//   IDLE: grant = first valid requester after the rr pointer (cyclic). req_ready_o[g]=1 for that
//    requester only, combinational from req_valid_i. All-zero when no valid. On handshake:
//    latch A/B (and the signed flag), id<=g, pointer<=g, cnt<=MULT_CYCLES-1, go to COMPUTE.
//   COMPUTE: req_ready_o=0. While cnt!=0, decrement cnt. At cnt==0, register the product into
//    result_o, set result_valid_o=1, go to DONE.
//   DONE: hold result_o, result_id_o and result_valid_o stable. When result_ready_i=1, clear
//    result_valid_o and go to IDLE. result_o keeps its last value.
//  Latency: handshake at edge E -> result_valid_o high from edge E+MULT_CYCLES. Minimum issue
//   interval is MULT_CYCLES+2 cycles, because IDLE always takes one cycle (no DONE->accept bypass).
//  Requesters must hold valid and operands stable until their ready is seen. Dropping valid
//   early is legal only before a grant.
//  Simultaneous valids: exactly one is granted. Non-granted requesters wait. Starvation bound =
//   N_REQ-1 grants. Pointer wraps N_REQ-1 -> 0.
//  Arithmetic: unsigned DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH, exact, no overflow possible.
// CONFIGURATION
//  MUL_SCHED_SIGNED_EN defined:
//   - req_signed_i port exists.
//   - Signed requests multiply |A| and |B| (|-2^(W-1)| = 2^(W-1) fits unsigned W bits).
//   - The product is negated to 2W bits when the operand signs differ.
//  MUL_SCHED_SIGNED_EN undefined: no port; every request is unsigned; no abs/negate logic.
// STRUCTURE
//  Package shared_multiplier_scheduler_pkg:
//   - state enum (IDLE, COMPUTE, DONE)
//   - id width function
//   - result struct {product, id}
//  Sub-module rr_arbiter:
//   - inputs: request vector, pointer
//   - outputs: one-hot grant and its index
//  Multiplier: one long_multiplier #(DATA_WIDTH) instance fed from the operand registers.
// TESTING (DATA_WIDTH=8, N_REQ=4, MULT_CYCLES=2)
//  1 req0 A=0x0F B=0x11, result_ready_i=1 -> result_o=0x00FF, id=0, valid 2 edges after accept.
//  2 all four valids held continuously -> grant order 0,1,2,3,0,1. Each id appears once per 4 results.
//  3 result_ready_i=0 for 10 cycles in DONE -> result_o/id/valid stable, req_ready_o=0, busy_o=1.
//  4 A=0xFF B=0xFF -> 0xFE01; A=0x00 B=0xA5 -> 0x0000; A=0x80 B=0x02 -> 0x0100.
//  5 rst_n_i=0 during COMPUTE -> next cycle: valid=0, busy=0, result_o=0. Next grant goes to req 0.
//  6 SIGNED_EN build: 0x80*0x80 signed=0x4000; 0xFF*0x01 signed=0xFFFF, unsigned=0x00FF.

Source files
------------

// File: rtl/shared_multiplier_scheduler_pkg.sv
// Shared types and helpers for the shared multiplier scheduler.
// Holds the FSM state encoding, the id-width helper and the result record
// for the default geometry (8-bit operands, 4 requesters).
package shared_multiplier_scheduler_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_N_REQ       = 4;
    localparam int DEF_MULT_CYCLES = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_ID_W = id_width(DEF_N_REQ);

    typedef struct packed {
        logic [2*DEF_DATA_WIDTH-1:0] product;
        logic [DEF_ID_W-1:0]         id;
    } result_t;

endpackage

// File: rtl/long_multiplier.sv
// Purely combinational unsigned WIDTH x WIDTH -> 2*WIDTH multiplier.
// Timing is relaxed by the scheduler, which holds the operands stable
// for several cycles before sampling the product.
module long_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product
);

    assign product = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/shared_multiplier_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request strictly after
// the pointer, wrapping cyclically, and reports it one-hot and as an index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             grant_any
);

    logic [ID_W:0] scan_idx;

    // Scan ptr+1 .. ptr+N_REQ (mod N_REQ); the first hit wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            end
            if (!grant_any && req[scan_idx[ID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_id  = scan_idx[ID_W-1:0];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_id == ID_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/shared_multiplier_scheduler.sv
// Shares one combinational long_multiplier among N_REQ requesters.
// A round-robin arbiter grants one request, the operands are latched and the
// multiplier is given MULT_CYCLES cycles to settle before the product is
// registered and tagged with the owning requester id.
// Optional feature macro: MUL_SCHED_SIGNED_EN adds req_signed_i and
// two's-complement handling (magnitudes multiplied, product negated when
// operand signs differ).
module shared_multiplier_scheduler
    import shared_multiplier_scheduler_pkg::*;
#(
    parameter  int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter  int N_REQ       = DEF_N_REQ,
    parameter  int MULT_CYCLES = DEF_MULT_CYCLES,
    localparam int ID_W        = id_width(N_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [N_REQ-1:0]            req_valid_i,
    output logic [N_REQ-1:0]            req_ready_o,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_operand_A_i,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_operand_B_i,
`ifdef MUL_SCHED_SIGNED_EN
    input  logic [N_REQ-1:0]            req_signed_i,
`endif
    output logic                        result_valid_o,
    input  logic                        result_ready_i,
    output logic [2*DATA_WIDTH-1:0]     result_o,
    output logic [ID_W-1:0]             result_id_o,
    output logic                        busy_o
);

    localparam int CNT_W = id_width(MULT_CYCLES);

    state_t                  state_reg;
    logic [ID_W-1:0]         ptr_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [DATA_WIDTH-1:0]   op_a_reg;
    logic [DATA_WIDTH-1:0]   op_b_reg;
    logic [2*DATA_WIDTH-1:0] result_reg;
    logic [ID_W-1:0]         result_id_reg;
    logic                    valid_reg;
    logic                    busy_reg;

    logic [N_REQ-1:0]        grant;
    logic [ID_W-1:0]         grant_id;
    logic                    grant_any;

    logic [DATA_WIDTH-1:0]   op_a_slice [N_REQ];
    logic [DATA_WIDTH-1:0]   op_b_slice [N_REQ];
    logic [DATA_WIDTH-1:0]   sel_a;
    logic [DATA_WIDTH-1:0]   sel_b;
    logic [DATA_WIDTH-1:0]   op_a_next;
    logic [DATA_WIDTH-1:0]   op_b_next;
    logic [2*DATA_WIDTH-1:0] raw_product;
    logic [2*DATA_WIDTH-1:0] product_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign op_a_slice[gi] = req_operand_A_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign op_b_slice[gi] = req_operand_B_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arbiter (
        .req       (req_valid_i),
        .ptr       (ptr_reg),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign sel_a = op_a_slice[grant_id];
    assign sel_b = op_b_slice[grant_id];

`ifdef MUL_SCHED_SIGNED_EN
    logic sel_signed;
    logic neg_next;
    logic neg_reg;

    // The most negative value's magnitude still fits in DATA_WIDTH unsigned bits.
    assign sel_signed   = req_signed_i[grant_id];
    assign op_a_next    = (sel_signed && sel_a[DATA_WIDTH-1]) ? -sel_a : sel_a;
    assign op_b_next    = (sel_signed && sel_b[DATA_WIDTH-1]) ? -sel_b : sel_b;
    assign neg_next     = sel_signed && (sel_a[DATA_WIDTH-1] ^ sel_b[DATA_WIDTH-1]);
    assign product_next = neg_reg ? -raw_product : raw_product;
`else
    assign op_a_next    = sel_a;
    assign op_b_next    = sel_b;
    assign product_next = raw_product;
`endif

    long_multiplier #(
        .WIDTH (DATA_WIDTH)
    ) u_mult (
        .a       (op_a_reg),
        .b       (op_b_reg),
        .product (raw_product)
    );

    assign req_ready_o    = (state_reg == ST_IDLE) ? grant : '0;
    assign result_valid_o = valid_reg;
    assign result_o       = result_reg;
    assign result_id_o    = result_id_reg;
    assign busy_o         = busy_reg;

    // Scheduler FSM: accept one request, wait out the multicycle path, hold the result until taken.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= ID_W'(N_REQ-1);
            cnt_reg       <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            result_reg    <= '0;
            result_id_reg <= '0;
            valid_reg     <= 1'b0;
            busy_reg      <= 1'b0;
`ifdef MUL_SCHED_SIGNED_EN
            neg_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        op_a_reg  <= op_a_next;
                        op_b_reg  <= op_b_next;
`ifdef MUL_SCHED_SIGNED_EN
                        neg_reg   <= neg_next;
`endif
                        ptr_reg   <= grant_id;
                        cnt_reg   <= CNT_W'(MULT_CYCLES-1);
                        busy_reg  <= 1'b1;
                        state_reg <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        result_reg    <= product_next;
                        result_id_reg <= ptr_reg;
                        valid_reg     <= 1'b1;
                        state_reg     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (result_ready_i) begin
                        valid_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
